load_store_unit: RTL and testbench

Multi-cycle data-memory access stage directly upstream of the write-back mux. It takes load/store ops from the control unit, using the effective address computed by the ALU. It runs a request/acknowledge transaction on the data bus and stalls the core until that transaction completes. For loads it returns right-aligned raw data on `memload`; the write-back stage applies sign or zero extension.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and data memory.
interface load_store_unit_if;
  logic        busRead;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busSel;
  logic [31:0] busRData;
  logic        busAck;

  modport master (
    output busRead,
    output busWrite,
    output busAddr,
    output busWData,
    output busSel,
    input  busRData,
    input  busAck
  );

  modport slave (
    input  busRead,
    input  busWrite,
    input  busAddr,
    input  busWData,
    input  busSel,
    output busRData,
    output busAck
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: req/ack data bus, stalls core until done.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [5:0]        cuOP,
  input  logic              exec,
  input  logic [31:0]       addr,
  input  logic [31:0]       storeData,
  load_store_unit_if.master bus,
  output logic [31:0]       memload,
  output logic              freeze,
  output logic              lsuErr
);

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LH  = 6'd11;
  localparam logic [5:0] OP_LW  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd13;
  localparam logic [5:0] OP_LHU = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  state_t      state_q;
  state_t      state_d;
  logic        is_mem;
  logic        is_ld;
  size_t       sz;
  logic        mis;
  logic [3:0]  sel;
  logic [31:0] wdata;

  logic        ld_q;
  size_t       sz_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;

  logic        go_req;
  logic        ld_hit;
  logic        err_d;
  logic        expire;
  logic [31:0] shifted;
  logic [31:0] ld_mask;

  always_comb begin
    is_mem = 1'b0;
    is_ld  = 1'b0;
    sz     = SZ_B;
    case (cuOP)
      OP_LB, OP_LBU: begin
        is_mem = 1'b1;
        is_ld  = 1'b1;
      end
      OP_LH, OP_LHU: begin
        is_mem = 1'b1;
        is_ld  = 1'b1;
        sz     = SZ_H;
      end
      OP_LW: begin
        is_mem = 1'b1;
        is_ld  = 1'b1;
        sz     = SZ_W;
      end
      OP_SB: is_mem = 1'b1;
      OP_SH: begin
        is_mem = 1'b1;
        sz     = SZ_H;
      end
      OP_SW: begin
        is_mem = 1'b1;
        sz     = SZ_W;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel   = 4'b0001 << addr[1:0];
    wdata = {4{storeData[7:0]}};
    mis   = 1'b0;
    unique case (1'b1)
      sz == SZ_W: begin
        sel   = 4'b1111;
        wdata = storeData;
        mis   = addr[1:0] != 2'b00;
      end
      sz == SZ_H: begin
        sel   = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{storeData[15:0]}};
        mis   = addr[0];
      end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;

  assign expire = cnt_q == TO_LAST;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else if (go_req) begin
      cnt_q <= '0;
    end else if (state_q == REQ && !bus.busAck) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    go_req  = 1'b0;
    ld_hit  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exec && is_mem) begin
          if (mis) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            go_req  = 1'b1;
          end
        end
      end
      REQ: begin
        // ack beats timeout when both land in the same cycle
        if (bus.busAck) begin
          state_d = DONE;
          ld_hit  = ld_q;
        end else if (expire) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign shifted = bus.busRData >> {off_q, 3'b000};

  always_comb begin
    ld_mask = 32'h0000_00ff;
    unique case (1'b1)
      sz_q == SZ_W: ld_mask = 32'hffff_ffff;
      sz_q == SZ_H: ld_mask = 32'h0000_ffff;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ld_q    <= 1'b0;
      sz_q    <= SZ_B;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      memload <= '0;
      lsuErr  <= 1'b0;
    end else begin
      if (go_req) begin
        ld_q    <= is_ld;
        sz_q    <= sz;
        off_q   <= addr[1:0];
        addr_q  <= {addr[31:2], 2'b00};
        wdata_q <= wdata;
        sel_q   <= sel;
      end
      if (ld_hit) begin
        memload <= shifted & ld_mask;
      end
      lsuErr <= err_d;
    end
  end

  assign bus.busRead  = (state_q == REQ) && ld_q;
  assign bus.busWrite = (state_q == REQ) && !ld_q;
  assign bus.busAddr  = addr_q;
  assign bus.busWData = wdata_q;
  assign bus.busSel   = sel_q;

  assign freeze = (state_q == IDLE && exec && is_mem)
                || (state_q == REQ);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a transaction-level model.
// Timeout cases run only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [5:0]  cuOP = '0;
  logic        exec = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] storeData = '0;
  logic [31:0] memload;
  logic        freeze;
  logic        lsuErr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_ml = '0;

  load_store_unit_if bus_if ();

  load_store_unit #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .cuOP     (cuOP),
    .exec     (exec),
    .addr     (addr),
    .storeData(storeData),
    .bus      (bus_if),
    .memload  (memload),
    .freeze   (freeze),
    .lsuErr   (lsuErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [5:0] op);
    case (op)
      6'd10, 6'd13, 6'd15: return 1;
      6'd11, 6'd14, 6'd16: return 2;
      6'd12, 6'd17:        return 4;
      default:             return 0;
    endcase
  endfunction

  task automatic run_op(input logic [5:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input logic [31:0] rd,
                        input int          waits);
    int sz;
    int nreq;
    bit ld;
    bit mis;
    bit tmo;
    bit err;
    logic [31:0] e_sel;
    logic [31:0] e_wd;
    logic [31:0] e_ml;
    logic [31:0] sh;
    sz   = op_size(op);
    ld   = (op >= 6'd10) && (op <= 6'd14);
    mis  = (sz != 0) && ((a % sz) != 0);
    tmo  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo  = !mis && (waits >= TO);
`endif
    err  = mis || tmo;
    nreq = mis ? 0 : (tmo ? TO : waits + 1);
    if (sz == 1) begin
      e_sel = 32'(1 << (a % 4));
      e_wd  = (sd % 256) * 32'h0101_0101;
    end else if (sz == 2) begin
      e_sel = ((a % 4) >= 2) ? 32'd12 : 32'd3;
      e_wd  = (sd % 65536) * 32'h0001_0001;
    end else begin
      e_sel = 32'd15;
      e_wd  = sd;
    end
    sh = rd / (32'd1 << (8 * (a % 4)));
    e_ml = model_ml;
    if (ld && !err) begin
      if (sz == 1)      e_ml = sh % 256;
      else if (sz == 2) e_ml = sh % 65536;
      else              e_ml = rd;
    end

    @(posedge clk); #1;
    cuOP = op; addr = a; storeData = sd; exec = 1'b1;
    bus_if.busAck = 1'b0;
    @(negedge clk);
    check("frz_idle", freeze, 32'(sz != 0));
    check("rd_idle", bus_if.busRead, 0);
    check("wr_idle", bus_if.busWrite, 0);
    if (sz == 0) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("nomem_frz", freeze, 0);
      check("nomem_rd", bus_if.busRead, 0);
      check("nomem_wr", bus_if.busWrite, 0);
      @(posedge clk); #1;
      exec = 1'b0;
      return;
    end
    for (int n = 0; n < nreq; n++) begin
      @(posedge clk); #1;
      bus_if.busAck   = (n == waits);
      bus_if.busRData = (n == waits) ? rd : $urandom;
      @(negedge clk);
      check("req_rd", bus_if.busRead, 32'(ld));
      check("req_wr", bus_if.busWrite, 32'(!ld));
      check("req_addr", bus_if.busAddr, a & 32'hffff_fffc);
      check("req_sel", bus_if.busSel, e_sel);
      if (!ld) check("req_wd", bus_if.busWData, e_wd);
      check("req_frz", freeze, 1);
      check("req_ml", memload, model_ml);
      check("req_err", lsuErr, 0);
    end
    @(posedge clk); #1;
    bus_if.busAck   = 1'($urandom_range(0, 1));
    bus_if.busRData = $urandom;
    @(negedge clk);
    check("done_frz", freeze, 0);
    check("done_rd", bus_if.busRead, 0);
    check("done_wr", bus_if.busWrite, 0);
    check("done_err", lsuErr, 32'(err));
    check("done_ml", memload, e_ml);
    model_ml = e_ml;
    @(posedge clk); #1;
    exec = 1'b0;
    @(negedge clk);
    check("post_frz", freeze, 0);
    check("post_err", lsuErr, 0);
    check("post_rd", bus_if.busRead, 0);
    check("post_wr", bus_if.busWrite, 0);
    check("post_ml", memload, model_ml);
    bus_if.busAck = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    int r;
    bus_if.busAck   = 1'b0;
    bus_if.busRData = '0;
    #3;
    check("rst_rd", bus_if.busRead, 0);
    check("rst_wr", bus_if.busWrite, 0);
    check("rst_addr", bus_if.busAddr, 0);
    check("rst_wd", bus_if.busWData, 0);
    check("rst_sel", bus_if.busSel, 0);
    check("rst_ml", memload, 0);
    check("rst_err", lsuErr, 0);
    check("rst_frz", freeze, 0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;

    run_op(6'd13, 32'h0000_1003, $urandom, 32'hA1B2C3D4, 0);
    check("lbu_ml", memload, 32'h0000_00A1);
    run_op(6'd16, 32'h0000_2002, 32'h0000_BEEF, $urandom, 3);
    check("sh_ml", memload, 32'h0000_00A1);
    run_op(6'd12, 32'h0000_3001, $urandom, $urandom, 0);
    run_op(6'd28, 32'h0000_3000, $urandom, $urandom, 0);

    @(posedge clk); #1;
    cuOP = 6'd12; addr = 32'h0000_4000; exec = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstq_rd", bus_if.busRead, 1);
    #2;
    bus_if.busAck = 1'b1;
    nRst = 1'b0;
    #1;
    check("rstq_rd0", bus_if.busRead, 0);
    check("rstq_ml", memload, 0);
    check("rstq_sel", bus_if.busSel, 0);
    @(negedge clk);
    exec = 1'b0;
    bus_if.busAck = 1'b0;
    nRst = 1'b1;
    model_ml = '0;
    #1;
    check("rstq_frz", freeze, 0);
    @(negedge clk);
    check("rstq_idle_rd", bus_if.busRead, 0);
    check("rstq_idle_ml", memload, 0);

`ifdef LSU_TIMEOUT_EN
    run_op(6'd12, 32'h0000_5000, $urandom, 32'h1234_5678, 10);
    run_op(6'd12, 32'h0000_5004, $urandom, 32'h8765_4321, TO - 1);
    check("to_ack_ml", memload, 32'h8765_4321);
`endif

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       op = 6'(10 + r);
      else if (r == 8) op = 6'd28;
      else             op = 6'd5;
      run_op(op, $urandom, $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
